// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: FSM state encoding and
// architectural constants.
package writeback_stage_pkg;

   typedef enum logic [1:0] {
      WB_RUN       = 2'd0,
      WB_WAIT_LOAD = 2'd1,
      WB_FLUSH     = 2'd2
   } wb_state_e;

   localparam logic [4:0]  REG_ZERO         = 5'd0;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/writeback_stage_regfile.sv
// General register file: NREG x XLEN flops, one write port, x0 hardwired
// to zero, all entries exposed flattened for forwarding.
module wb_regfile
   import writeback_stage_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_we,
   input  logic [4:0]           i_waddr,
   input  logic [XLEN-1:0]      i_wdata,
   output logic [NREG*XLEN-1:0] o_rdata_flat
);

   logic [XLEN-1:0] r_regs [NREG];

   // Register storage; x0 is never written so it stays at its reset value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we && (i_waddr != REG_ZERO)) begin
         r_regs[i_waddr] <= i_wdata;
      end else begin
         r_regs <= r_regs;
      end
   end

   // Flatten the array for the forwarding network.
   always_comb begin
      o_rdata_flat = '0;
      for (int i = 0; i < NREG; i++) begin
         o_rdata_flat[i*XLEN +: XLEN] = r_regs[i];
      end
   end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: commits execute/load results, tracks the PC and
// flushes after redirects. Optional retire counter under WB_RETIRE_CNT_EN.
module writeback_stage
   import writeback_stage_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              NREG     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ex_valid,
   output logic                 ex_ready,
   input  logic [XLEN-1:0]      ex_pc,
   input  logic                 ex_we,
   input  logic [4:0]           ex_rd,
   input  logic [XLEN-1:0]      ex_rd_value,
   input  logic                 ex_redirect,
   input  logic [XLEN-1:0]      ex_target,
   input  logic                 dm_req,
   input  logic [4:0]           dm_req_rd,
   input  logic [XLEN-1:0]      dm_req_pc,
   input  logic                 dm_rsp_valid,
   input  logic [XLEN-1:0]      dm_rsp_data,
   output logic [NREG*XLEN-1:0] gpr_flat,
   output logic [XLEN-1:0]      pc_reg,
   output logic                 flush,
`ifdef WB_RETIRE_CNT_EN
   output logic [63:0]          retire_cnt,
`endif
   output logic                 busy
);

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   wb_state_e       r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_ld_pc;
   logic [4:0]      r_ld_rd;
   logic            r_flush;

   logic            w_commit;
   logic            w_ld_done;
   logic            w_rf_we;
   logic [4:0]      w_rf_waddr;
   logic [XLEN-1:0] w_rf_wdata;

   assign w_commit  = (r_state == WB_RUN) && ex_valid && !dm_req;
   assign w_ld_done = (r_state == WB_WAIT_LOAD) && dm_rsp_valid;

   // Register-file write mux: execute commit or load completion.
   always_comb begin
      w_rf_we    = 1'b0;
      w_rf_waddr = REG_ZERO;
      w_rf_wdata = '0;
      if (w_commit) begin
         w_rf_we    = ex_we;
         w_rf_waddr = ex_rd;
         w_rf_wdata = ex_rd_value;
      end else if (w_ld_done) begin
         w_rf_we    = 1'b1;
         w_rf_waddr = r_ld_rd;
         w_rf_wdata = dm_rsp_data;
      end else begin
         w_rf_we    = 1'b0;
      end
   end

   wb_regfile #(
      .XLEN (XLEN),
      .NREG (NREG)
   ) u_regfile (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_we         (w_rf_we),
      .i_waddr      (w_rf_waddr),
      .i_wdata      (w_rf_wdata),
      .o_rdata_flat (gpr_flat)
   );

   // Stage FSM, PC register and pending-load bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= WB_RUN;
         r_pc    <= RESET_PC;
         r_ld_pc <= '0;
         r_ld_rd <= REG_ZERO;
         r_flush <= 1'b0;
      end else begin
         r_flush <= 1'b0;
         case (r_state)
            WB_RUN: begin
               if (dm_req) begin
                  r_state <= WB_WAIT_LOAD;
                  r_ld_rd <= dm_req_rd;
                  r_ld_pc <= dm_req_pc;
               end else if (ex_valid) begin
                  r_pc <= ex_redirect ? ex_target : (ex_pc + PC_STEP);
                  if (ex_redirect) begin
                     r_state <= WB_FLUSH;
                     r_flush <= 1'b1;
                  end else begin
                     r_state <= WB_RUN;
                  end
               end else begin
                  r_state <= WB_RUN;
               end
            end
            WB_WAIT_LOAD: begin
               if (dm_rsp_valid) begin
                  r_pc    <= r_ld_pc + PC_STEP;
                  r_state <= WB_RUN;
               end else begin
                  r_state <= WB_WAIT_LOAD;
               end
            end
            // Wrong-path instruction arriving here is simply not committed.
            WB_FLUSH: begin
               r_state <= WB_RUN;
            end
            default: begin
               r_state <= WB_RUN;
            end
         endcase
      end
   end

`ifdef WB_RETIRE_CNT_EN
   logic [63:0] r_retire_cnt;

   // Count every retired instruction (commit or load completion).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_retire_cnt <= 64'd0;
      end else if (w_commit || w_ld_done) begin
         r_retire_cnt <= r_retire_cnt + 64'd1;
      end else begin
         r_retire_cnt <= r_retire_cnt;
      end
   end

   assign retire_cnt = r_retire_cnt;
`endif

   assign pc_reg   = r_pc;
   assign flush    = r_flush;
   assign busy     = (r_state != WB_RUN);
   assign ex_ready = (r_state == WB_FLUSH) || ((r_state == WB_RUN) && !dm_req);

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage; define WB_RETIRE_CNT_EN
// to also exercise the retire counter.
module tb_writeback_stage;

   localparam int XLEN = 32;
   localparam int NREG = 32;

   logic                 clk;
   logic                 rst_n;
   logic                 ex_valid;
   logic                 ex_ready;
   logic [XLEN-1:0]      ex_pc;
   logic                 ex_we;
   logic [4:0]           ex_rd;
   logic [XLEN-1:0]      ex_rd_value;
   logic                 ex_redirect;
   logic [XLEN-1:0]      ex_target;
   logic                 dm_req;
   logic [4:0]           dm_req_rd;
   logic [XLEN-1:0]      dm_req_pc;
   logic                 dm_rsp_valid;
   logic [XLEN-1:0]      dm_rsp_data;
   logic [NREG*XLEN-1:0] gpr_flat;
   logic [XLEN-1:0]      pc_reg;
   logic                 flush;
   logic                 busy;
`ifdef WB_RETIRE_CNT_EN
   logic [63:0]          retire_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   writeback_stage #(
      .XLEN (XLEN),
      .NREG (NREG)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ex_valid     (ex_valid),
      .ex_ready     (ex_ready),
      .ex_pc        (ex_pc),
      .ex_we        (ex_we),
      .ex_rd        (ex_rd),
      .ex_rd_value  (ex_rd_value),
      .ex_redirect  (ex_redirect),
      .ex_target    (ex_target),
      .dm_req       (dm_req),
      .dm_req_rd    (dm_req_rd),
      .dm_req_pc    (dm_req_pc),
      .dm_rsp_valid (dm_rsp_valid),
      .dm_rsp_data  (dm_rsp_data),
      .gpr_flat     (gpr_flat),
      .pc_reg       (pc_reg),
      .flush        (flush),
`ifdef WB_RETIRE_CNT_EN
      .retire_cnt   (retire_cnt),
`endif
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [XLEN-1:0] gpr(input int idx);
      return gpr_flat[idx*XLEN +: XLEN];
   endfunction

   task automatic idle();
      ex_valid     = 1'b0;
      ex_pc        = 32'h0;
      ex_we        = 1'b0;
      ex_rd        = 5'd0;
      ex_rd_value  = 32'h0;
      ex_redirect  = 1'b0;
      ex_target    = 32'h0;
      dm_req       = 1'b0;
      dm_req_rd    = 5'd0;
      dm_req_pc    = 32'h0;
      dm_rsp_valid = 1'b0;
      dm_rsp_data  = 32'h0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic commit(input logic [31:0] pc, input logic we, input logic [4:0] rd,
                         input logic [31:0] val, input logic redir, input logic [31:0] tgt);
      idle();
      ex_valid    = 1'b1;
      ex_pc       = pc;
      ex_we       = we;
      ex_rd       = rd;
      ex_rd_value = val;
      ex_redirect = redir;
      ex_target   = tgt;
      step();
      idle();
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      #12;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      logic all_zero;
      idle();
      rst_n = 1'b0;
      #12;
      all_zero = (gpr_flat == '0);
      check_eq("reset_gpr_zero", 64'(all_zero), 64'd1);
      check_eq("reset_pc", 64'(pc_reg), 64'h0);
      check_eq("reset_flush", 64'(flush), 64'd0);
      check_eq("reset_busy", 64'(busy), 64'd0);
      check_eq("reset_ex_ready", 64'(ex_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      commit(32'h100, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 32'h0);
      check_eq("commit_x5", 64'(gpr(5)), 64'hDEAD_BEEF);
      check_eq("commit_pc", 64'(pc_reg), 64'h104);

      commit(32'h104, 1'b1, 5'd0, 32'h1234, 1'b0, 32'h0);
      check_eq("x0_write_ignored", 64'(gpr(0)), 64'h0);
      check_eq("x0_pc", 64'(pc_reg), 64'h108);

      commit(32'h108, 1'b0, 5'd0, 32'h0, 1'b1, 32'h200);
      check_eq("redirect_pc", 64'(pc_reg), 64'h200);
      check_eq("redirect_flush", 64'(flush), 64'd1);
      check_eq("flush_busy", 64'(busy), 64'd1);
      check_eq("flush_ex_ready", 64'(ex_ready), 64'd1);
      commit(32'h10C, 1'b1, 5'd7, 32'h55, 1'b0, 32'h0);
      check_eq("flushed_x7", 64'(gpr(7)), 64'h0);
      check_eq("flushed_pc", 64'(pc_reg), 64'h200);
      check_eq("flush_one_cycle", 64'(flush), 64'd0);
      check_eq("after_flush_busy", 64'(busy), 64'd0);

      commit(32'hFFFF_FFFC, 1'b1, 5'd1, 32'h11, 1'b0, 32'h0);
      check_eq("pc_wrap", 64'(pc_reg), 64'h0);
      check_eq("wrap_x1", 64'(gpr(1)), 64'h11);

      commit(32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h301);
      check_eq("target_bit0_kept", 64'(pc_reg), 64'h301);
      step();

      dm_rsp_valid = 1'b1;
      dm_rsp_data  = 32'h9999;
      step();
      idle();
      check_eq("rsp_in_run_busy", 64'(busy), 64'd0);
      check_eq("rsp_in_run_pc", 64'(pc_reg), 64'h301);

      dm_req    = 1'b1;
      dm_req_rd = 5'd3;
      dm_req_pc = 32'h40;
      ex_valid  = 1'b1;
      ex_we     = 1'b1;
      ex_rd     = 5'd4;
      ex_rd_value = 32'hBAD;
      ex_pc     = 32'h3C;
      #1;
      check_eq("dm_req_blocks_ready", 64'(ex_ready), 64'd0);
      step();
      idle();
      check_eq("dm_req_prio_x4", 64'(gpr(4)), 64'h0);
      for (int k = 0; k < 3; k++) begin
         check_eq($sformatf("wait_busy_%0d", k), 64'(busy), 64'd1);
         check_eq($sformatf("wait_ready_%0d", k), 64'(ex_ready), 64'd0);
         if (k < 2) step();
      end
      dm_rsp_valid = 1'b1;
      dm_rsp_data  = 32'hCAFE;
      step();
      idle();
      check_eq("load_x3", 64'(gpr(3)), 64'hCAFE);
      check_eq("load_pc", 64'(pc_reg), 64'h44);
      check_eq("load_busy_clear", 64'(busy), 64'd0);

      dm_req    = 1'b1;
      dm_req_rd = 5'd9;
      dm_req_pc = 32'h80;
      step();
      idle();
      check_eq("wait_before_reset", 64'(busy), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      all_zero = (gpr_flat == '0);
      check_eq("midload_reset_gpr", 64'(all_zero), 64'd1);
      check_eq("midload_reset_pc", 64'(pc_reg), 64'h0);
      check_eq("midload_reset_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dm_rsp_valid = 1'b1;
      dm_rsp_data  = 32'h77;
      step();
      idle();
      check_eq("stale_rsp_x9", 64'(gpr(9)), 64'h0);
      check_eq("stale_rsp_pc", 64'(pc_reg), 64'h0);

`ifdef WB_RETIRE_CNT_EN
      do_reset();
      check_eq("retire_reset", retire_cnt, 64'd0);
      commit(32'h0, 1'b1, 5'd1, 32'h1, 1'b0, 32'h0);
      commit(32'h4, 1'b1, 5'd2, 32'h2, 1'b0, 32'h0);
      commit(32'h8, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
      commit(32'hC, 1'b1, 5'd6, 32'h6, 1'b0, 32'h0);
      commit(32'h10, 1'b0, 5'd0, 32'h0, 1'b1, 32'h400);
      commit(32'h14, 1'b1, 5'd8, 32'h8, 1'b0, 32'h0);
      dm_req    = 1'b1;
      dm_req_rd = 5'd10;
      dm_req_pc = 32'h400;
      step();
      idle();
      dm_rsp_valid = 1'b1;
      dm_rsp_data  = 32'hA;
      step();
      idle();
      check_eq("retire_cnt", retire_cnt, 64'd6);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
